// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Purpose  : Asynchronous serial receiver (8N1 by default). Synchronises the
//            raw rx line, derives an oversample tick from the system clock,
//            detects the start bit, samples each bit at mid-bit, checks the
//            stop bit and reports each byte with a one-cycle strobe.
// Ports    : clk       - system clock, rising edge
//            rst_n     - synchronous active-low reset
//            rx_in     - raw asynchronous serial line, idle high
//            rx_data   - last correctly framed payload
//            rx_valid  - one-cycle pulse, rx_data updated
//            frame_err - one-cycle pulse, stop bit sampled low
//            busy      - frame in progress
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int c_div   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int c_div_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int c_s_w   = $clog2(OVERSAMPLE);
    localparam int c_b_w   = $clog2(DATA_BITS);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
    localparam logic [c_s_w-1:0]   c_s_half   = c_s_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_s_w-1:0]   c_s_last   = c_s_w'(OVERSAMPLE - 1);
    localparam logic [c_b_w-1:0]   c_b_last   = c_b_w'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_sync1;
    logic                   r_rx_s;
    logic                   r_rx_d;
    logic [c_div_w-1:0]     r_div;
    logic [c_s_w-1:0]       r_s_cnt;
    logic [c_b_w-1:0]       r_b_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_ferr;

    logic                   w_tick;
    logic                   w_fall;
    logic                   w_div_clr;
    logic                   w_cnt_clr;
    logic                   w_bit_clr;
    logic                   w_shift;
    logic                   w_good;
    logic                   w_bad;

    assign w_tick = (r_div == c_div_last);
    // Only a high-to-low transition starts a frame, so a held-low break
    // line cannot retrigger until it has returned high.
    assign w_fall = r_rx_d & ~r_rx_s;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_div_clr   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_bit_clr   = 1'b0;
        w_shift     = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = ST_START;
                    w_div_clr   = 1'b1;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick && (r_s_cnt == c_s_half)) begin
                    if (!r_rx_s) begin
                        w_state_nxt = ST_DATA;
                        w_cnt_clr   = 1'b1;
                        w_bit_clr   = 1'b1;
                    end else begin
                        // Line back high at mid start bit: treat as a glitch.
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick && (r_s_cnt == c_s_last)) begin
                    w_shift   = 1'b1;
                    w_cnt_clr = 1'b1;
                    if (r_b_cnt == c_b_last) begin
                        w_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick && (r_s_cnt == c_s_last)) begin
                    w_state_nxt = ST_IDLE;
                    if (r_rx_s) begin
                        w_good = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Synchroniser, divider, counters and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
            r_div   <= '0;
            r_s_cnt <= '0;
            r_b_cnt <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= rx_in;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;

            // Clearing the divider at the start edge aligns bit timing to it.
            if (w_div_clr || w_tick) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_cnt_clr) begin
                r_s_cnt <= '0;
            end else if (w_tick) begin
                r_s_cnt <= r_s_cnt + 1'b1;
            end

            if (w_bit_clr) begin
                r_b_cnt <= '0;
            end else if (w_shift) begin
                r_b_cnt <= r_b_cnt + 1'b1;
            end

            // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
            if (w_shift) begin
                r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            end

            if (w_good) begin
                r_data <= r_shift;
            end
            r_valid <= w_good;
            r_ferr  <= w_bad;
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Purpose  : Directed self-checking bench for uart_rx_core at 32 clk per bit
//            (CLK_FREQ=3.2 MHz, BAUD_RATE=100 kbaud, OVERSAMPLE=16, 8 bits).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int c_bit_clks = 32;

    logic       clk;
    logic       rst_n;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    uart_rx_core #(
        .CLK_FREQ   (3_200_000),
        .BAUD_RATE  (100_000),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_dbl = 0;
    int         n_excl = 0;
    int         busy_run = 0;
    int         busy_max = 0;
    logic [7:0] last_data = 8'h00;
    time        t_valid = 0;
    time        t_busy_rise = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ferr = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] q_data[$];

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            n_valid++;
            last_data = rx_data;
            t_valid   = $time;
            q_data.push_back(rx_data);
        end
        if (frame_err === 1'b1) n_ferr++;
        if ((rx_valid === 1'b1 && prev_valid) || (frame_err === 1'b1 && prev_ferr)) n_dbl++;
        if (rx_valid === 1'b1 && frame_err === 1'b1) n_excl++;
        if (busy === 1'b1) begin
            if (!prev_busy) t_busy_rise = $time;
            busy_run++;
            if (busy_run > busy_max) busy_max = busy_run;
        end else begin
            busy_run = 0;
        end
        prev_valid = (rx_valid === 1'b1);
        prev_ferr  = (frame_err === 1'b1);
        prev_busy  = (busy === 1'b1);
    end

    time t_edge;

    // Drives one bit for a full bit period; called on a falling edge.
    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (c_bit_clks) @(negedge clk);
    endtask

    // Sends one frame. If rst_bit is a data-bit index, a one-clock reset is
    // pulsed mid-way through that bit and the sender abandons the frame
    // (line back to idle), as a transmitter sharing the reset would.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int rst_bit);
        t_edge = $time;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                rx_in = d[i];
                repeat (c_bit_clks / 2) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                rx_in = 1'b1;
                return;
            end
            drive_bit(d[i]);
        end
        drive_bit(stop_bit);
    endtask

    int v0;
    int f0;
    int lat;

    initial begin
        rst_n = 1'b0;
        rx_in = 1'b1;
        @(posedge clk);

        // Reset held for 3 clk with the line toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_data", {24'h0, rx_data}, 32'h00);
            chk("rst_valid", {31'h0, rx_valid}, 32'h0);
            chk("rst_ferr", {31'h0, frame_err}, 32'h0);
            chk("rst_busy", {31'h0, busy}, 32'h0);
            rx_in = ~rx_in;
        end
        @(negedge clk);
        rst_n = 1'b1;
        rx_in = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_busy", {31'h0, busy}, 32'h0);

        // Single byte 0xA5
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'hA5, 1'b1, -1);
        repeat (40) @(negedge clk);
        chk("a5_count", n_valid - v0, 1);
        chk("a5_data", {24'h0, last_data}, 32'hA5);
        lat = int'((t_valid - t_edge) / 10);
        chk("a5_latency_window", {31'h0, (lat >= 304 && lat <= 310)}, 32'h1);
        lat = int'((t_busy_rise - t_edge) / 10);
        chk("a5_busy_rise", {31'h0, (lat >= 2 && lat <= 4)}, 32'h1);
        chk("a5_ferr", n_ferr - f0, 0);
        chk("a5_busy_end", {31'h0, busy}, 32'h0);

        // Back-to-back frames with one-bit stops
        q_data.delete();
        f0 = n_ferr;
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h3C, 1'b1, -1);
        repeat (40) @(negedge clk);
        chk("b2b_count", q_data.size(), 3);
        if (q_data.size() == 3) begin
            chk("b2b_0", {24'h0, q_data[0]}, 32'h00);
            chk("b2b_1", {24'h0, q_data[1]}, 32'hFF);
            chk("b2b_2", {24'h0, q_data[2]}, 32'h3C);
        end
        chk("b2b_ferr", n_ferr - f0, 0);

        // Framing error: 0x55 with stop bit low, then recovery with 0x81
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h55, 1'b0, -1);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        chk("ferr_count", n_ferr - f0, 1);
        chk("ferr_no_valid", n_valid - v0, 0);
        chk("ferr_data_held", {24'h0, rx_data}, 32'h3C);
        send_frame(8'h81, 1'b1, -1);
        repeat (40) @(negedge clk);
        chk("ferr_next_count", n_valid - v0, 1);
        chk("ferr_next_data", {24'h0, rx_data}, 32'h81);

        // Glitch: 8-clk low pulse on an idle line
        v0 = n_valid;
        f0 = n_ferr;
        busy_max = 0;
        rx_in = 1'b0;
        repeat (8) @(negedge clk);
        rx_in = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_busy_seen", {31'h0, (busy_max >= 1)}, 32'h1);
        chk("glitch_busy_max", {31'h0, (busy_max <= 20)}, 32'h1);
        chk("glitch_no_valid", n_valid - v0, 0);
        chk("glitch_no_ferr", n_ferr - f0, 0);
        chk("glitch_idle", {31'h0, busy}, 32'h0);

        // Reset during bit 4 of 0x7E, then 0x42
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h7E, 1'b1, 4);
        repeat (400) @(negedge clk);
        chk("rstmid_no_valid", n_valid - v0, 0);
        chk("rstmid_no_ferr", n_ferr - f0, 0);
        chk("rstmid_data", {24'h0, rx_data}, 32'h00);
        chk("rstmid_busy", {31'h0, busy}, 32'h0);
        send_frame(8'h42, 1'b1, -1);
        repeat (40) @(negedge clk);
        chk("rstmid_next_count", n_valid - v0, 1);
        chk("rstmid_next_data", {24'h0, rx_data}, 32'h42);

        // Strobe properties over the whole run
        chk("pulse_width", n_dbl, 0);
        chk("pulse_exclusive", n_excl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
